uart_avm_ctrl: RTL and testbench

// - Avalon-MM master that sequences the Nios-system UART (rxdata/txdata/status/control regs) from fabric logic.
// - Shares the UART transmitter between NUM_REQ byte requesters with a round-robin arbiter and a single-byte holding register.
// - Polls UART status, drains received bytes to a valid-pulse output and records sticky line errors.

---
 rtl/uart_avm_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_avm_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_avm_ctrl.sv
// uart_avm_ctrl: Avalon-MM master that sequences a Nios-system UART.
// Status is polled on a fixed interval. Received bytes leave on a one-cycle
// valid pulse, and line errors collect in sticky flags. NUM_REQ byte requesters
// share the transmitter through a round-robin arbiter that feeds a single-byte
// holding register.
module uart_avm_ctrl #(
  parameter int NUM_REQ  = 2,
  parameter int POLL_DIV = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   tx_req,
  input  logic [NUM_REQ*8-1:0] tx_data,
  output logic [NUM_REQ-1:0]   tx_gnt,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  output logic [2:0]           err_flags,
  input  logic                 err_clr,
  output logic [2:0]           avm_address,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [15:0]          avm_writedata,
  input  logic [15:0]          avm_readdata,
  input  logic                 avm_waitrequest
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  // POLL_DIV of 0 or 1 both leave IDLE after a single cycle.
  localparam logic [TMR_W-1:0] TMR_LAST = (POLL_DIV > 1) ? TMR_W'(POLL_DIV - 1) : '0;

  // UART register word offsets
  localparam logic [2:0] ADDR_RXDATA = 3'd0;
  localparam logic [2:0] ADDR_TXDATA = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_STAT,
    S_DECIDE,
    S_RD_RX,
    S_WR_TX,
    S_CLR_ST
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [7:0]         stat;
  logic               hold_valid;
  logic [7:0]         hold_byte;
  logic [PTR_W-1:0]   ptr;

  logic               grant_any;
  logic               grant_ok;
  logic [PTR_W-1:0]   grant_idx;
  logic [7:0]         grant_byte;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [2:0]         new_err;
  logic               tx_done;
  logic               rx_done;
  logic               stat_done;

  // Requester index (base + off), wrapped modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Round-robin search: the first request at or after ptr wins.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!grant_any && tx_req[wrap_idx(ptr, off)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(ptr, off);
      end
    end
    grant_byte = tx_data[8*int'(grant_idx) +: 8];
    // hold_valid is registered, so the cycle that frees the holder cannot grant.
    grant_ok   = grant_any && !hold_valid;
    gnt_vec    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_vec[i] = grant_ok && (PTR_W'(i) == grant_idx);
    end
  end

  assign stat_done = (state == S_RD_STAT) && !avm_waitrequest;
  assign rx_done   = (state == S_RD_RX)   && !avm_waitrequest;
  assign tx_done   = (state == S_WR_TX)   && !avm_waitrequest;
  // Error bits are ordered {ROE, FE, PE}. They are sampled only in DECIDE.
  assign new_err   = (state == S_DECIDE) ? {stat[3], stat[1], stat[0]} : 3'b000;

  // Holding register, round-robin pointer and grant pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the data byte is reset too, so writedata never carries X after a reset.
      hold_valid <= 1'b0;
      hold_byte  <= 8'h00;
      ptr        <= '0;
      tx_gnt     <= '0;
    end else begin
      tx_gnt <= gnt_vec;
      if (tx_done) begin
        hold_valid <= 1'b0;
      end else if (grant_ok) begin
        hold_valid <= 1'b1;
        hold_byte  <= grant_byte;
        ptr        <= wrap_idx(grant_idx, 1);
      end
    end
  end

  // Bus sequencer state, poll timer, status latch, RX byte and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      stat      <= 8'h00;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      err_flags <= 3'b000;
    end else begin
      state    <= state_nxt;
      rx_valid <= rx_done;
      if (state == S_IDLE) begin
        timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
      end
      if (stat_done) stat <= avm_readdata[7:0];
      if (rx_done) rx_data <= avm_readdata[7:0];
      // A new error wins over a clear in the same cycle.
      err_flags <= err_clr ? new_err : (err_flags | new_err);
    end
  end

  // Next state and Avalon command. The command depends only on the state, so it holds through wait states.
  always_comb begin
    state_nxt     = state;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = 3'd0;
    avm_writedata = 16'h0000;
    unique case (state)
      S_IDLE: begin
        if (timer == TMR_LAST) state_nxt = S_RD_STAT;
      end
      S_RD_STAT: begin
        avm_read    = 1'b1;
        avm_address = ADDR_STATUS;
        if (!avm_waitrequest) state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        if (stat[0] || stat[1] || stat[3]) state_nxt = S_CLR_ST;
        else if (stat[7])                  state_nxt = S_RD_RX;
        else if (stat[6] && hold_valid)    state_nxt = S_WR_TX;
        else                               state_nxt = S_IDLE;
      end
      S_RD_RX: begin
        avm_read    = 1'b1;
        avm_address = ADDR_RXDATA;
        if (!avm_waitrequest) state_nxt = S_IDLE;
      end
      S_WR_TX: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_TXDATA;
        avm_writedata = {8'h00, hold_byte};
        if (!avm_waitrequest) state_nxt = S_IDLE;
      end
      S_CLR_ST: begin
        avm_write   = 1'b1;
        avm_address = ADDR_STATUS;
        if (!avm_waitrequest) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_avm_ctrl.sv
// tb_uart_avm_ctrl: directed bench for uart_avm_ctrl. A small UART slave
// model answers the bus. A negedge monitor logs bus completions, grants and
// RX pulses, and directed scenarios compare the logs with hand-computed values.
module tb_uart_avm_ctrl;

  localparam int NUM_REQ  = 2;
  localparam int POLL_DIV = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   tx_req;
  logic [NUM_REQ*8-1:0] tx_data;
  logic [NUM_REQ-1:0]   tx_gnt;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic [2:0]           err_flags;
  logic                 err_clr;
  logic [2:0]           avm_address;
  logic                 avm_read;
  logic                 avm_write;
  logic [15:0]          avm_writedata;
  logic [15:0]          avm_readdata;
  logic                 avm_waitrequest;

  uart_avm_ctrl #(.NUM_REQ(NUM_REQ), .POLL_DIV(POLL_DIV)) dut (
    .clk(clk), .reset(reset),
    .tx_req(tx_req), .tx_data(tx_data), .tx_gnt(tx_gnt),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .err_flags(err_flags), .err_clr(err_clr),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART slave model
  logic [15:0] stat_reg;
  logic [7:0]  rx_byte;
  int          stall_left;
  logic [2:0]  stall_addr;

  assign avm_readdata = (avm_read && avm_address == 3'd2) ? stat_reg :
                        (avm_read && avm_address == 3'd0) ? {8'h00, rx_byte} : 16'h0000;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    int          at;
  } ev_t;

  int          cyc = 0;
  ev_t         ev_q[$];
  int          stat_cyc_q[$];
  int          wr_lat_q[$];
  logic [1:0]  gnt_q[$];
  logic [7:0]  rxv_q[$];
  int          rxv_cyc_q[$];
  int          wr_cycles;
  int          last_stat_cyc;
  logic        stat_done;
  logic        prev_wait;
  logic [20:0] prev_cmd;

  always @(posedge clk) cyc++;

  // Slave wait states, protocol checks and event logging, away from the active edge.
  always @(negedge clk) begin
    if ((avm_read || avm_write) && avm_address == stall_addr && stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
    if (!reset) begin
      check("rw_exclusive", {31'd0, avm_read & avm_write}, 32'd0);
      if (prev_wait) check("cmd_stable", {11'd0, avm_read, avm_write, avm_address, avm_writedata}, {11'd0, prev_cmd});
      if (avm_write) wr_cycles++;
      stat_done = avm_read && avm_address == 3'd2 && !avm_waitrequest;
      if (stat_done) begin
        stat_cyc_q.push_back(cyc);
        last_stat_cyc = cyc;
      end
      if (avm_read && avm_address == 3'd0 && !avm_waitrequest) begin
        ev_q.push_back('{1'b0, avm_address, 16'h0000, cyc});
        stat_reg[7] = 1'b0;
      end
      if (avm_write && !avm_waitrequest) begin
        ev_q.push_back('{1'b1, avm_address, avm_writedata, cyc});
        if (avm_address == 3'd1) wr_lat_q.push_back(cyc - last_stat_cyc);
        if (avm_address == 3'd2) stat_reg = stat_reg & ~16'h000B;
      end
      if (tx_gnt != '0) gnt_q.push_back(tx_gnt);
      if (rx_valid) begin
        rxv_q.push_back(rx_data);
        rxv_cyc_q.push_back(cyc);
      end
      prev_wait = (avm_read || avm_write) && avm_waitrequest;
      prev_cmd  = {avm_read, avm_write, avm_address, avm_writedata};
    end else begin
      prev_wait = 1'b0;
      stat_done = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ev_q.delete(); stat_cyc_q.delete(); wr_lat_q.delete();
    gnt_q.delete(); rxv_q.delete(); rxv_cyc_q.delete();
    wr_cycles = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tx_req = '0; err_clr = 1'b0; stall_left = 0; stat_reg = 16'h0000;
    tick(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},   {30'd0, tx_gnt}, 32'd0);
    check({tag, "_rxv"},   {31'd0, rx_valid}, 32'd0);
    check({tag, "_rxd"},   {24'd0, rx_data}, 32'd0);
    check({tag, "_err"},   {29'd0, err_flags}, 32'd0);
    check({tag, "_rd"},    {31'd0, avm_read}, 32'd0);
    check({tag, "_wr"},    {31'd0, avm_write}, 32'd0);
    check({tag, "_addr"},  {29'd0, avm_address}, 32'd0);
    check({tag, "_wdata"}, {16'd0, avm_writedata}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tx_req = '0; tx_data = '0; err_clr = 1'b0;
    stat_reg = 16'h0000; rx_byte = 8'h00; stall_left = 0; stall_addr = 3'd7;
    avm_waitrequest = 1'b0; wr_cycles = 0; last_stat_cyc = 0;
    prev_wait = 1'b0; prev_cmd = '0; stat_done = 1'b0;

    // Reset state
    tick(2);
    check_quiet("reset");
    reset = 1'b0;
    clear_logs();

    // Idle polling: DECIDE + 3 IDLE cycles + status read = 5-cycle period
    tick(30);
    check("poll_count", {31'd0, stat_cyc_q.size() >= 3}, 32'd1);
    if (stat_cyc_q.size() >= 3) begin
      check("poll_period0", stat_cyc_q[1] - stat_cyc_q[0], 32'd5);
      check("poll_period1", stat_cyc_q[2] - stat_cyc_q[1], 32'd5);
    end
    check("poll_no_events", ev_q.size(), 32'd0);

    // Round robin: both requesters held, TRDY=1
    do_reset();
    stat_reg = 16'h0040;
    tx_data  = {8'hB2, 8'hA1};
    tx_req   = 2'b11;
    for (int i = 0; i < 400 && wr_lat_q.size() < 4; i++) tick(1);
    tx_req = 2'b00;
    check("rr_done", {31'd0, wr_lat_q.size() >= 4}, 32'd1);
    if (wr_lat_q.size() >= 4 && gnt_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr_addr%0d", i), {29'd0, ev_q[i].addr}, 32'd1);
        check($sformatf("rr_data%0d", i), {16'd0, ev_q[i].data}, (i % 2 == 0) ? 32'h00A1 : 32'h00B2);
        check($sformatf("rr_gnt%0d", i),  {30'd0, gnt_q[i]},     (i % 2 == 0) ? 32'd1 : 32'd2);
        check($sformatf("rr_lat%0d", i),  wr_lat_q[i], 32'd2);
      end
    end

    // Wait states on the txdata write: 3 stalled cycles + 1 accepted
    do_reset();
    stat_reg   = 16'h0040;
    stall_addr = 3'd1;
    stall_left = 3;
    tx_data    = {8'h00, 8'h41};
    tx_req     = 2'b01;
    for (int i = 0; i < 100 && gnt_q.size() < 1; i++) tick(1);
    tx_req = 2'b00;
    for (int i = 0; i < 100 && ev_q.size() < 1; i++) tick(1);
    tick(20);
    check("ws_events", ev_q.size(), 32'd1);
    if (ev_q.size() >= 1) begin
      check("ws_addr", {29'd0, ev_q[0].addr}, 32'd1);
      check("ws_data", {16'd0, ev_q[0].data}, 32'h0041);
    end
    check("ws_cycles", wr_cycles, 32'd4);
    check("ws_gnts", gnt_q.size(), 32'd1);

    // Reset during a stalled WR_TX drops the write and the held byte
    do_reset();
    stat_reg   = 16'h0040;
    stall_addr = 3'd1;
    stall_left = 1000;
    tx_data    = {8'h00, 8'h41};
    tx_req     = 2'b01;
    for (int i = 0; i < 100 && gnt_q.size() < 1; i++) tick(1);
    tx_req = 2'b00;
    for (int i = 0; i < 100 && !avm_write; i++) tick(1);
    check("rst_wr_seen", {31'd0, avm_write}, 32'd1);
    tick(2);
    reset = 1'b1;
    tick(1);
    check_quiet("rst_mid");
    stall_left = 0;
    reset = 1'b0;
    clear_logs();
    tick(30);
    check("rst_hold_drop", ev_q.size(), 32'd0);

    // RX has priority over a pending TX byte
    do_reset();
    rx_byte = 8'h5A;
    tx_data = {8'h77, 8'h00};
    tx_req  = 2'b10;
    for (int i = 0; i < 100 && gnt_q.size() < 1; i++) tick(1);
    tx_req = 2'b00;
    if (gnt_q.size() >= 1) check("rxp_gnt", {30'd0, gnt_q[0]}, 32'd2);
    tick(10);
    check("rxp_no_tx", ev_q.size(), 32'd0);
    stat_reg = 16'h00C0;
    for (int i = 0; i < 100 && ev_q.size() < 2; i++) tick(1);
    check("rxp_events", {31'd0, ev_q.size() >= 2}, 32'd1);
    if (ev_q.size() >= 2) begin
      check("rxp_first", {28'd0, ev_q[0].wr, ev_q[0].addr}, 32'h0);
      check("rxp_second", {28'd0, ev_q[1].wr, ev_q[1].addr}, 32'h9);
      check("rxp_txdata", {16'd0, ev_q[1].data}, 32'h0077);
    end
    check("rxp_pulses", rxv_q.size(), 32'd1);
    if (rxv_q.size() >= 1 && ev_q.size() >= 1) begin
      check("rxp_byte", {24'd0, rxv_q[0]}, 32'h5A);
      check("rxp_lat", rxv_cyc_q[0] - ev_q[0].at, 32'd1);
    end

    // TRDY=0 with a held byte: no write, no further grants
    do_reset();
    tx_data = {8'hB2, 8'hA1};
    tx_req  = 2'b11;
    tick(40);
    check("trdy0_gnts", gnt_q.size(), 32'd1);
    if (gnt_q.size() >= 1) check("trdy0_gnt0", {30'd0, gnt_q[0]}, 32'd1);
    check("trdy0_no_wr", ev_q.size(), 32'd0);
    stat_reg = 16'h0040;
    for (int i = 0; i < 100 && (ev_q.size() < 1 || gnt_q.size() < 2); i++) tick(1);
    tx_req = 2'b00;
    if (ev_q.size() >= 1) check("trdy1_data", {16'd0, ev_q[0].data}, 32'h00A1);
    if (gnt_q.size() >= 2) check("trdy1_gnt1", {30'd0, gnt_q[1]}, 32'd2);
    check("trdy1_seen", {31'd0, ev_q.size() >= 1 && gnt_q.size() >= 2}, 32'd1);

    // Errors: FE+ROE set flags and clear status
    do_reset();
    stat_reg = 16'h000A;
    for (int i = 0; i < 100 && ev_q.size() < 1; i++) tick(1);
    tick(3);
    check("err_flags", {29'd0, err_flags}, 32'b110);
    if (ev_q.size() >= 1) check("err_clr_wr", {ev_q[0].wr, ev_q[0].addr, 12'd0, ev_q[0].data}, {1'b1, 3'd2, 28'd0});
    tick(20);
    check("err_sticky", {29'd0, err_flags}, 32'b110);
    check("err_one_clr", ev_q.size(), 32'd1);

    // err_clr in the DECIDE cycle that sees a new PE
    stat_reg = 16'h0001;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (stat_done) break;
    end
    #1 err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_clr_pe", {29'd0, err_flags}, 32'b001);
    tick(10);
    check("err_pe_sticky", {29'd0, err_flags}, 32'b001);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_clr_only", {29'd0, err_flags}, 32'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
